// File: rtl/dcache_block_ctrl.sv
// Data-cache block sequencer: victim writeback, line fill and syscall flush walk
// over the data-memory block port.
module dcache_block_ctrl #(
   parameter int unsigned NUM_LINES  = 32,
   parameter int unsigned INDEX_BITS = 5
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  miss_req,
   input  logic [31:0]           miss_addr,
   input  logic                  victim_dirty,
   input  logic [31:0]           victim_addr,
   input  logic [255:0]          victim_block,
   input  logic                  flush_req,
   input  logic [255:0]          block_read_fDM,
   input  logic                  block_read_fDM_valid,
   input  logic                  block_write_fDM_valid,
   output logic                  dBlkRead,
   output logic                  dBlkWrite,
   output logic [31:0]           blk_address_2DM,
   output logic [255:0]          block_write_2DM,
   output logic                  fill_valid,
   output logic [255:0]          fill_block,
   output logic [INDEX_BITS-1:0] flush_index,
   output logic                  invalidate_line,
   output logic                  flush_done,
   output logic                  STALL
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WB      = 3'd1;
   localparam logic [2:0] FILL    = 3'd2;
   localparam logic [2:0] RESP    = 3'd3;
   localparam logic [2:0] FL_CHK  = 3'd4;
   localparam logic [2:0] FL_WB   = 3'd5;
   localparam logic [2:0] FL_INV  = 3'd6;
   localparam logic [2:0] FL_DONE = 3'd7;

   localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(NUM_LINES - 1);

   logic [2:0]            state;
   logic [2:0]            stateNext;
   logic [26:0]           missLine;
   logic [26:0]           blkLine;
   logic [255:0]          wrData;
   logic [255:0]          fillData;
   logic [INDEX_BITS-1:0] flushIdx;

   // Block addresses are line aligned, so the byte-offset bits are never needed.
   logic unusedAddrBits;
   assign unusedAddrBits = ^{miss_addr[4:0], victim_addr[4:0]};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (miss_req)       stateNext = victim_dirty ? WB : FILL;
            else if (flush_req) stateNext = FL_CHK;
         end
         WB:      if (block_write_fDM_valid) stateNext = FILL;
         FILL:    if (block_read_fDM_valid)  stateNext = RESP;
         RESP:    stateNext = IDLE;
         FL_CHK:  stateNext = victim_dirty ? FL_WB : FL_INV;
         FL_WB:   if (block_write_fDM_valid) stateNext = FL_INV;
         FL_INV:  stateNext = (flushIdx == LAST_INDEX) ? FL_DONE : FL_CHK;
         FL_DONE: if (!flush_req) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Request address/data are captured on entry so they stay constant until the strobe.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         missLine <= '0;
         blkLine  <= '0;
         wrData   <= '0;
         fillData <= '0;
         flushIdx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_req) begin
                  missLine <= miss_addr[31:5];
                  wrData   <= victim_block;
                  blkLine  <= victim_dirty ? victim_addr[31:5] : miss_addr[31:5];
               end else if (flush_req) begin
                  flushIdx <= '0;
               end
            end
            WB:      if (block_write_fDM_valid) blkLine <= missLine;
            FILL:    if (block_read_fDM_valid) fillData <= block_read_fDM;
            FL_CHK: begin
               if (victim_dirty) begin
                  blkLine <= victim_addr[31:5];
                  wrData  <= victim_block;
               end
            end
            FL_INV:  if (flushIdx != LAST_INDEX) flushIdx <= flushIdx + INDEX_BITS'(1);
            FL_DONE: if (!flush_req) flushIdx <= '0;
            default: ;
         endcase
      end
   end

   assign dBlkWrite       = (state == WB) || (state == FL_WB);
   assign dBlkRead        = (state == FILL);
   assign fill_valid      = (state == RESP);
   assign invalidate_line = (state == FL_INV);
   assign flush_done      = (state == FL_DONE);
   assign blk_address_2DM = {blkLine, 5'b0};
   assign block_write_2DM = wrData;
   assign fill_block      = fillData;
   assign flush_index     = flushIdx;
   // Requests stall in IDLE before the FSM reacts; reset forces the stall low.
   assign STALL = (state != IDLE) || (!RESET && (miss_req || flush_req));

endmodule

// File: tb/tb_dcache_block_ctrl.sv
// Directed bench for dcache_block_ctrl: per-cycle vector table for misses,
// hand sequences for flush walk, miss/flush priority and async reset.
module tb_dcache_block_ctrl;
   localparam int unsigned NUM_LINES  = 32;
   localparam int unsigned INDEX_BITS = 5;
   localparam logic [255:0] PAT   = {32{8'hA5}};
   localparam logic [255:0] PAT2  = {32{8'h3C}};
   localparam logic [255:0] VDATA = {8{32'hDEADBEEF}};
   localparam logic [255:0] VDAT2 = {8{32'h12345678}};

   logic CLK = 1'b0;
   logic RESET;
   logic miss_req, flush_req;
   logic [31:0] miss_addr, victimAddrDrv, victim_addr;
   logic victimDirtyDrv, victim_dirty;
   logic [255:0] victim_block, block_read_fDM;
   logic rdValidDrv, wrValidDrv, autoRd, autoWr, flushDirty;
   logic block_read_fDM_valid, block_write_fDM_valid;
   logic dBlkRead, dBlkWrite, fill_valid, invalidate_line, flush_done, STALL;
   logic [31:0] blk_address_2DM;
   logic [255:0] block_write_2DM, fill_block;
   logic [INDEX_BITS-1:0] flush_index;

   int nCompared = 0;
   int nMismatched = 0;

   always #5 CLK = ~CLK;

   assign victim_dirty = flushDirty ? (flush_index == 5'd3 || flush_index == 5'd31) : victimDirtyDrv;
   assign victim_addr  = flushDirty ? {22'h2, flush_index, 5'b0} : victimAddrDrv;
   assign block_read_fDM_valid  = autoRd ? dBlkRead  : rdValidDrv;
   assign block_write_fDM_valid = autoWr ? dBlkWrite : wrValidDrv;

   dcache_block_ctrl #(.NUM_LINES(NUM_LINES), .INDEX_BITS(INDEX_BITS)) dut (
      .CLK(CLK), .RESET(RESET),
      .miss_req(miss_req), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_block(victim_block),
      .flush_req(flush_req),
      .block_read_fDM(block_read_fDM), .block_read_fDM_valid(block_read_fDM_valid),
      .block_write_fDM_valid(block_write_fDM_valid),
      .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite),
      .blk_address_2DM(blk_address_2DM), .block_write_2DM(block_write_2DM),
      .fill_valid(fill_valid), .fill_block(fill_block),
      .flush_index(flush_index), .invalidate_line(invalidate_line),
      .flush_done(flush_done), .STALL(STALL)
   );

   task automatic chkW(input string name, input logic [255:0] act, input logic [255:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chkW(name, 256'(act), 256'(exp));
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      chkW(name, 256'(act), 256'(exp));
   endtask

   typedef struct {
      logic miss, dirty, flush, rdV, wrV;
      logic eRd, eWr;
      logic [31:0] eAddr;
      logic eFv, eStall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic miss, input logic dirty, input logic flush,
                               input logic rdV, input logic wrV, input logic eRd,
                               input logic eWr, input logic [31:0] eAddr,
                               input logic eFv, input logic eStall);
      vec_t v;
      v.miss = miss; v.dirty = dirty; v.flush = flush; v.rdV = rdV; v.wrV = wrV;
      v.eRd = eRd; v.eWr = eWr; v.eAddr = eAddr; v.eFv = eFv; v.eStall = eStall;
      return v;
   endfunction

   initial begin
      int wrBursts, invCount, readSeen, invEarly, c;
      logic prevWr, done, gotFill, gotInv;
      logic [31:0] burstAddr[2];

      RESET = 1'b1; miss_req = 0; flush_req = 0; miss_addr = 32'h0000_1234;
      victimAddrDrv = 32'h0000_2040; victimDirtyDrv = 0; victim_block = VDATA;
      block_read_fDM = PAT; rdValidDrv = 0; wrValidDrv = 0;
      autoRd = 0; autoWr = 0; flushDirty = 0;

      // Clean miss (read valid on 4th FILL cycle), dirty miss with stray strobes,
      // then the minimum-latency clean miss.
      vecs.push_back(mk(1,0,0,0,0, 0,0,32'h0,    0,1));
      vecs.push_back(mk(1,0,0,0,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,0,0,0,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,0,0,0,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,0,0,1,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,32'h0,    1,1));
      vecs.push_back(mk(0,0,0,0,0, 0,0,32'h0,    0,0));
      vecs.push_back(mk(1,1,0,0,0, 0,0,32'h0,    0,1));
      vecs.push_back(mk(1,1,0,0,0, 0,1,32'h2040, 0,1));
      vecs.push_back(mk(1,1,0,0,1, 0,1,32'h2040, 0,1));
      vecs.push_back(mk(1,1,0,0,1, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,1,0,0,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,1,0,1,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,1,0,0,0, 0,0,32'h0,    1,1));
      vecs.push_back(mk(0,0,0,1,1, 0,0,32'h0,    0,0));
      vecs.push_back(mk(0,0,0,0,0, 0,0,32'h0,    0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,32'h0,    0,1));
      vecs.push_back(mk(1,0,0,1,0, 1,0,32'h1220, 0,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,32'h0,    1,1));
      vecs.push_back(mk(0,0,0,0,0, 0,0,32'h0,    0,0));

      // Reset state
      @(negedge CLK); #1;
      chk1("rst.rd", dBlkRead, 0);         chk1("rst.wr", dBlkWrite, 0);
      chk32("rst.addr", blk_address_2DM, 0); chkW("rst.wdata", block_write_2DM, '0);
      chk1("rst.fv", fill_valid, 0);       chkW("rst.fblk", fill_block, '0);
      chk32("rst.idx", 32'(flush_index), 0); chk1("rst.inv", invalidate_line, 0);
      chk1("rst.done", flush_done, 0);     chk1("rst.stall", STALL, 0);
      @(negedge CLK); RESET = 1'b0;

      foreach (vecs[i]) begin
         @(negedge CLK);
         miss_req = vecs[i].miss; victimDirtyDrv = vecs[i].dirty; flush_req = vecs[i].flush;
         rdValidDrv = vecs[i].rdV; wrValidDrv = vecs[i].wrV;
         #1;
         chk1($sformatf("row%0d.rd", i), dBlkRead, vecs[i].eRd);
         chk1($sformatf("row%0d.wr", i), dBlkWrite, vecs[i].eWr);
         chk1($sformatf("row%0d.fv", i), fill_valid, vecs[i].eFv);
         chk1($sformatf("row%0d.stall", i), STALL, vecs[i].eStall);
         chk1($sformatf("row%0d.inv", i), invalidate_line, 0);
         if (vecs[i].eRd || vecs[i].eWr)
            chk32($sformatf("row%0d.addr", i), blk_address_2DM, vecs[i].eAddr);
         if (vecs[i].eWr) chkW($sformatf("row%0d.wdata", i), block_write_2DM, VDATA);
         if (vecs[i].eFv) chkW($sformatf("row%0d.fblk", i), fill_block, PAT);
      end

      // Flush walk with lines 3 and 31 dirty, write strobe immediate
      @(negedge CLK);
      rdValidDrv = 0; wrValidDrv = 0; victim_block = VDAT2;
      flushDirty = 1; autoWr = 1; flush_req = 1;
      #1; chk1("fl.stallIdle", STALL, 1);
      wrBursts = 0; invCount = 0; readSeen = 0; prevWr = 0; done = 0;
      burstAddr[0] = '0; burstAddr[1] = '0;
      for (c = 0; c < 300 && !done; c++) begin
         @(negedge CLK); #1;
         if (dBlkRead) readSeen++;
         if (dBlkWrite && !prevWr) begin
            if (wrBursts < 2) burstAddr[wrBursts] = blk_address_2DM;
            chkW("fl.wdata", block_write_2DM, VDAT2);
            wrBursts++;
         end
         prevWr = dBlkWrite;
         if (invalidate_line) begin
            chk32("fl.invIdx", 32'(flush_index), 32'(invCount));
            invCount++;
         end
         if (flush_done) begin
            done = 1;
            chk32("fl.invBeforeDone", 32'(invCount), 32);
         end
      end
      chk1("fl.doneSeen", done, 1);
      chk32("fl.bursts", 32'(wrBursts), 2);
      chk32("fl.invCount", 32'(invCount), 32);
      chk32("fl.addr3", burstAddr[0], 32'h0000_0860);
      chk32("fl.addr31", burstAddr[1], 32'h0000_0BE0);
      chk32("fl.noRead", 32'(readSeen), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK); #1;
         chk1("fl.doneHold", flush_done, 1);
         chk1("fl.stallHold", STALL, 1);
      end
      @(negedge CLK); flush_req = 0;
      @(negedge CLK); #1;
      chk1("fl.doneDrop", flush_done, 0);
      chk32("fl.idxClr", 32'(flush_index), 0);
      chk1("fl.stallDrop", STALL, 0);
      flushDirty = 0; autoWr = 0;

      // Simultaneous miss and flush: miss first, walk starts at index 0
      @(negedge CLK);
      victimDirtyDrv = 0; miss_addr = 32'h0000_5678; block_read_fDM = PAT2;
      autoRd = 1; miss_req = 1; flush_req = 1;
      #1; chk1("pri.stall", STALL, 1);
      gotFill = 0; invEarly = 0;
      for (c = 0; c < 20 && !gotFill; c++) begin
         @(negedge CLK); #1;
         if (invalidate_line) invEarly++;
         if (fill_valid) gotFill = 1;
      end
      chk1("pri.fill", gotFill, 1);
      chkW("pri.fblk", fill_block, PAT2);
      chk32("pri.noInvEarly", 32'(invEarly), 0);
      chk32("pri.idx0", 32'(flush_index), 0);
      miss_req = 0;
      gotInv = 0;
      for (c = 0; c < 20 && !gotInv; c++) begin
         @(negedge CLK); #1;
         if (invalidate_line) begin
            gotInv = 1;
            chk32("pri.firstInv", 32'(flush_index), 0);
         end
      end
      chk1("pri.invSeen", gotInv, 1);
      done = 0;
      for (c = 0; c < 200 && !done; c++) begin
         @(negedge CLK); #1;
         if (flush_done) done = 1;
      end
      chk1("pri.flushDone", done, 1);
      @(negedge CLK); flush_req = 0; autoRd = 0;
      @(negedge CLK); #1;
      chk1("pri.idle", STALL, 0);

      // Async reset mid-FILL, then a late read strobe
      @(negedge CLK);
      miss_addr = 32'h0000_1234; rdValidDrv = 0; miss_req = 1;
      @(negedge CLK);
      @(negedge CLK); #1;
      chk1("rstm.rdBefore", dBlkRead, 1);
      #2 RESET = 1'b1;
      #1;
      chk1("rstm.rd", dBlkRead, 0);
      chk1("rstm.stall", STALL, 0);
      chk1("rstm.fv", fill_valid, 0);
      chkW("rstm.fblk", fill_block, '0);
      chk32("rstm.addr", blk_address_2DM, 0);
      @(negedge CLK); miss_req = 0; RESET = 1'b0;
      @(negedge CLK); rdValidDrv = 1; #1;
      chk1("rstm.idle", STALL, 0);
      @(negedge CLK); rdValidDrv = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1("rstm.noFill", fill_valid, 0);
         chk1("rstm.noRd", dBlkRead, 0);
         @(negedge CLK);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
